// File: rtl/bnn_link_pkg.sv
// Shared types and constants for the BNN accelerator host link.
// Contents:
//   link_state_e  - word-path sequencer states (idle, weight burst, image burst)
//   OP_WEIGHT / OP_IMAGE - command opcodes on cmd_op
//   WT_WORDS / IMG_WORDS - default burst lengths
//   LABEL_MAX     - largest legal class index; anything above is flagged bad
package bnn_link_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWeight,
    StImage
  } link_state_e;

  localparam logic OP_WEIGHT = 1'b0;
  localparam logic OP_IMAGE  = 1'b1;

  // 6 conv1 words followed by 60 fc1 words.
  localparam int unsigned WT_WORDS  = 66;
  localparam int unsigned IMG_WORDS = 200;
  localparam int unsigned LABEL_MAX = 9;

  function automatic logic label_bad(input logic [3:0] label);
    return label > 4'(LABEL_MAX);
  endfunction

endpackage

// File: rtl/bnn_label_rx.sv
// Label receiver for the BNN accelerator link.
// The accelerator returns each 4-bit class result as two 2-bit beats on
// out_en/dout, high pair first. This block pairs the beats, presents the
// nibble as a one-cycle result pulse and flags beats that arrive while no
// image is awaiting a label.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   out_en, dout  - label beat strobe and 2-bit payload from the accelerator
//   none_pending  - no image is currently awaiting a label
//   lbl_done      - combinational: this cycle's beat completes a label
//   res_valid     - one-cycle pulse, the edge after the low beat
//   res_label     - reassembled label (held until the next result)
//   res_bad       - high with res_valid when the label exceeds LABEL_MAX
//   err_spurious  - sticky: a beat arrived with nothing outstanding
module bnn_label_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       out_en,
  input  logic [1:0] dout,
  input  logic       none_pending,
  output logic       lbl_done,
  output logic       res_valid,
  output logic [3:0] res_label,
  output logic       res_bad,
  output logic       err_spurious
);
  import bnn_link_pkg::*;

  logic       hi_pend_q, hi_pend_d;
  logic [1:0] hi_q, hi_d;
  logic       res_valid_q, res_valid_d;
  logic [3:0] res_label_q, res_label_d;
  logic       res_bad_q, res_bad_d;
  logic       err_q, err_d;
  logic       spurious;
  logic       hi_take;
  logic [3:0] full_label;

  always_comb begin
    full_label = {hi_q, dout};
    lbl_done   = out_en && hi_pend_q;
    // A high beat with nothing outstanding is discarded, not latched.
    spurious   = out_en && !hi_pend_q && none_pending;
    hi_take    = out_en && !hi_pend_q && !none_pending;

    hi_pend_d   = hi_pend_q;
    hi_d        = hi_q;
    res_label_d = res_label_q;
    err_d       = err_q | spurious;

    if (hi_take) begin
      hi_pend_d = 1'b1;
      hi_d      = dout;
    end
    if (lbl_done) begin
      hi_pend_d   = 1'b0;
      res_label_d = full_label;
    end

    res_valid_d = lbl_done;
    res_bad_d   = lbl_done && label_bad(full_label);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_pend_q   <= 1'b0;
      hi_q        <= 2'b00;
      res_valid_q <= 1'b0;
      res_label_q <= 4'h0;
      res_bad_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hi_pend_q   <= hi_pend_d;
      hi_q        <= hi_d;
      res_valid_q <= res_valid_d;
      res_label_q <= res_label_d;
      res_bad_q   <= res_bad_d;
      err_q       <= err_d;
    end
  end

  assign res_valid    = res_valid_q;
  assign res_label    = res_label_q;
  assign res_bad      = res_bad_q;
  assign err_spurious = err_q;

endmodule

// File: rtl/bnn_host_link.sv
// Host-side initiator for the BNN accelerator's external link.
// Accepts load-weight / run-image commands, streams the matching number of
// host words onto the accelerator link through a one-deep output register
// (weights bit-reversed, image words unchanged), limits the number of
// images in flight without a returned label, and reassembles labels.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op     - command handshake (0 weights, 1 image)
//   wd_valid/wd_ready/wd_data      - host word stream
//   acc_mode/acc_valid/acc_data    - to accelerator mode/in_valid/data_in
//   acc_ready                      - from accelerator in_ready
//   acc_out_en/acc_dout            - label beats from the accelerator
//   res_valid/res_label/res_bad    - reassembled label result
//   err_spurious                   - sticky unexpected-label-beat flag
//   busy                           - burst in progress or labels pending
//   img_cnt/lbl_cnt                - wrapping image / label counters
module bnn_host_link #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned WT_WORDS  = bnn_link_pkg::WT_WORDS,
  parameter int unsigned IMG_WORDS = bnn_link_pkg::IMG_WORDS,
  parameter int unsigned MAX_OUT   = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              acc_mode,
  output logic              acc_valid,
  output logic [DATA_W-1:0] acc_data,
  input  logic              acc_ready,
  input  logic              acc_out_en,
  input  logic [1:0]        acc_dout,
  output logic              res_valid,
  output logic [3:0]        res_label,
  output logic              res_bad,
  output logic              err_spurious,
  output logic              busy,
  output logic [CNT_W-1:0]  img_cnt,
  output logic [CNT_W-1:0]  lbl_cnt
);
  import bnn_link_pkg::*;

  localparam int unsigned MaxWords = (WT_WORDS > IMG_WORDS) ? WT_WORDS : IMG_WORDS;
  localparam int unsigned WordCntW = $clog2(MaxWords + 1);
  localparam int unsigned OutW     = $clog2(MAX_OUT + 1);
  localparam logic [WordCntW-1:0] WtLen  = WordCntW'(WT_WORDS);
  localparam logic [WordCntW-1:0] ImgLen = WordCntW'(IMG_WORDS);
  localparam logic [OutW-1:0]     MaxOut = OutW'(MAX_OUT);

  link_state_e         state_q, state_d;
  logic [WordCntW-1:0] words_q, words_d;
  logic [WordCntW-1:0] burst_len;
  logic                acc_valid_q, acc_valid_d;
  logic [DATA_W-1:0]   acc_data_q, acc_data_d;
  logic [DATA_W-1:0]   wd_rev;
  logic                acc_mode_q, acc_mode_d;
  logic [OutW-1:0]     outst_q, outst_d;
  logic [CNT_W-1:0]    img_cnt_q, img_cnt_d;
  logic [CNT_W-1:0]    lbl_cnt_q, lbl_cnt_d;

  logic cmd_acc, wd_load, xfer, burst_done;
  logic outst_zero, img_inc, lbl_dec, lbl_done;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign outst_zero = (outst_q == '0);
  assign burst_len  = (state_q == StWeight) ? WtLen : ImgLen;
  assign cmd_acc    = cmd_valid && cmd_ready;
  assign wd_load    = wd_valid && wd_ready;
  assign xfer       = acc_valid_q && acc_ready;
  // Once N words are loaded no further load is possible, so the register
  // holds the last word and its transfer closes the burst.
  assign burst_done = xfer && (words_q == burst_len) && (state_q != StIdle);
  assign img_inc    = cmd_acc && (cmd_op == OP_IMAGE);
  assign lbl_dec    = lbl_done && !outst_zero;

  always_comb begin
    wd_rev = '0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      wd_rev[DATA_W-1-k] = wd_data[k];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_acc) begin
          state_d = (cmd_op == OP_WEIGHT) ? StWeight : StImage;
        end
      end
      StWeight, StImage: begin
        if (burst_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    wd_ready  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Weights may not change under images still awaiting labels.
        cmd_ready = !rst && (((cmd_op == OP_WEIGHT) && outst_zero) ||
                             ((cmd_op == OP_IMAGE) && (outst_q < MaxOut)));
      end
      StWeight, StImage: begin
        wd_ready = !rst && (words_q < burst_len) && (!acc_valid_q || acc_ready);
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle) || !outst_zero;

  // ---------------------------------------------------------------------------
  // Word register, mode, counters, outstanding tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_valid_d = acc_valid_q;
    acc_data_d  = acc_data_q;
    acc_mode_d  = acc_mode_q;
    words_d     = words_q;
    img_cnt_d   = img_cnt_q;
    lbl_cnt_d   = lbl_cnt_q;
    outst_d     = outst_q;

    if (xfer) begin
      acc_valid_d = 1'b0;
    end
    if (wd_load) begin
      acc_valid_d = 1'b1;
      acc_data_d  = (state_q == StWeight) ? wd_rev : wd_data;
      words_d     = words_q + WordCntW'(1);
    end
    if (cmd_acc) begin
      words_d    = '0;
      acc_mode_d = (cmd_op == OP_WEIGHT);
    end
    // Mode drops on the edge that empties the register, never under a beat.
    if (burst_done) begin
      acc_mode_d = 1'b0;
      if (state_q == StImage) begin
        img_cnt_d = img_cnt_q + CNT_W'(1);
      end
    end
    if (lbl_done) begin
      lbl_cnt_d = lbl_cnt_q + CNT_W'(1);
    end
    if (img_inc && !lbl_dec) begin
      outst_d = outst_q + OutW'(1);
    end else if (!img_inc && lbl_dec) begin
      outst_d = outst_q - OutW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_valid_q <= 1'b0;
      acc_data_q  <= '0;
      acc_mode_q  <= 1'b0;
      words_q     <= '0;
      img_cnt_q   <= '0;
      lbl_cnt_q   <= '0;
      outst_q     <= '0;
    end else begin
      acc_valid_q <= acc_valid_d;
      acc_data_q  <= acc_data_d;
      acc_mode_q  <= acc_mode_d;
      words_q     <= words_d;
      img_cnt_q   <= img_cnt_d;
      lbl_cnt_q   <= lbl_cnt_d;
      outst_q     <= outst_d;
    end
  end

  assign acc_valid = acc_valid_q;
  assign acc_data  = acc_data_q;
  assign acc_mode  = acc_mode_q;
  assign img_cnt   = img_cnt_q;
  assign lbl_cnt   = lbl_cnt_q;

  // ---------------------------------------------------------------------------
  // Label receiver
  // ---------------------------------------------------------------------------
  bnn_label_rx u_label_rx (
    .clk          (clk),
    .rst          (rst),
    .out_en       (acc_out_en),
    .dout         (acc_dout),
    .none_pending (outst_zero),
    .lbl_done     (lbl_done),
    .res_valid    (res_valid),
    .res_label    (res_label),
    .res_bad      (res_bad),
    .err_spurious (err_spurious)
  );

endmodule

// File: tb/tb_bnn_host_link.sv
// Directed bench for bnn_host_link: weight burst, backpressured image burst,
// label reassembly, outstanding limit, spurious beat and mid-burst reset.
module tb_bnn_host_link;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic        wd_valid, wd_ready;
  logic [15:0] wd_data;
  logic        acc_mode, acc_valid, acc_ready;
  logic [15:0] acc_data;
  logic        acc_out_en;
  logic [1:0]  acc_dout;
  logic        res_valid, res_bad, err_spurious, busy;
  logic [3:0]  res_label;
  logic [15:0] img_cnt, lbl_cnt;

  bnn_host_link dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .wd_valid     (wd_valid),
    .wd_ready     (wd_ready),
    .wd_data      (wd_data),
    .acc_mode     (acc_mode),
    .acc_valid    (acc_valid),
    .acc_data     (acc_data),
    .acc_ready    (acc_ready),
    .acc_out_en   (acc_out_en),
    .acc_dout     (acc_dout),
    .res_valid    (res_valid),
    .res_label    (res_label),
    .res_bad      (res_bad),
    .err_spurious (err_spurious),
    .busy         (busy),
    .img_cnt      (img_cnt),
    .lbl_cnt      (lbl_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Link monitor: beats, their mode, and stability while stalled.
  bit [15:0] beat_q[$];
  bit        beat_mode[$];
  int        stall_viol = 0;
  int        res_pulses = 0;
  bit        stall_prev = 0;
  bit [15:0] stall_data;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev && acc_valid && acc_data !== stall_data) stall_viol++;
      if (acc_valid && acc_ready) begin
        beat_q.push_back(acc_data);
        beat_mode.push_back(acc_mode);
      end
      stall_prev = acc_valid && !acc_ready;
      stall_data = acc_data;
      if (res_valid) res_pulses++;
    end
  end

  bit rdy_toggle = 0;
  initial begin
    acc_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      acc_ready = rdy_toggle ? !acc_ready : 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic op);
    int cyc = 0;
    bit got = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    while (!got && cyc < 20) begin
      @(negedge clk);
      got = cmd_ready;
      step();
      cyc++;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(got), 1);
  endtask

  task automatic send_words(input int n, input bit fixed, input logic [15:0] val);
    int  i = 0;
    int  cyc = 0;
    bit  took;
    while (i < n && cyc < 4 * n + 20) begin
      wd_valid = 1'b1;
      wd_data  = fixed ? val : 16'(i);
      @(negedge clk);
      took = wd_ready;
      step();
      if (took) i++;
      cyc++;
    end
    wd_valid = 1'b0;
    check("words_taken", 32'(i), 32'(n));
  endtask

  task automatic wait_beats(input int n);
    int cyc = 0;
    while (beat_q.size() < n && cyc < 1000) begin
      step();
      cyc++;
    end
    check("beat_count", 32'(beat_q.size()), 32'(n));
  endtask

  task automatic label_beat(input logic [1:0] d);
    acc_out_en = 1'b1;
    acc_dout   = d;
    step();
    acc_out_en = 1'b0;
    acc_dout   = 2'b00;
  endtask

  task automatic check_image_order(input string tag);
    int bad = 0;
    foreach (beat_q[i]) begin
      if (beat_q[i] !== 16'(i) || beat_mode[i] !== 1'b0) bad++;
    end
    check(tag, 32'(bad), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int p0;
    rst        = 1'b1;
    cmd_valid  = 1'b1;
    cmd_op     = 1'b0;
    wd_valid   = 1'b0;
    wd_data    = '0;
    acc_out_en = 1'b0;
    acc_dout   = 2'b00;

    // Reset state
    step();
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_acc_mode", 32'(acc_mode), 0);
    check("rst_acc_valid", 32'(acc_valid), 0);
    check("rst_acc_data", 32'(acc_data), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_label", 32'(res_label), 0);
    check("rst_res_bad", 32'(res_bad), 0);
    check("rst_err", 32'(err_spurious), 0);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_img_cnt", 32'(img_cnt), 0);
    check("rst_lbl_cnt", 32'(lbl_cnt), 0);

    // Weight load: 0x0001 reversed on the wire is 0x8000
    beat_q.delete();
    beat_mode.delete();
    do_cmd(1'b0);
    check("wt_mode_on", 32'(acc_mode), 1);
    check("wt_busy", 32'(busy), 1);
    send_words(66, 1'b1, 16'h0001);
    wait_beats(66);
    bad = 0;
    foreach (beat_q[i]) if (beat_q[i] !== 16'h8000 || beat_mode[i] !== 1'b1) bad++;
    check("wt_beats", 32'(bad), 0);
    check("wt_end_valid", 32'(acc_valid), 0);
    check("wt_end_mode", 32'(acc_mode), 0);
    check("wt_end_busy", 32'(busy), 0);
    check("wt_img_cnt", 32'(img_cnt), 0);

    // Image with acc_ready toggling
    rdy_toggle = 1;
    beat_q.delete();
    beat_mode.delete();
    stall_viol = 0;
    do_cmd(1'b1);
    check("img_mode", 32'(acc_mode), 0);
    send_words(200, 1'b0, 16'h0000);
    wait_beats(200);
    check_image_order("img_order");
    check("img_stall_stable", 32'(stall_viol), 0);
    check("img_cnt_1", 32'(img_cnt), 1);
    check("img_end_valid", 32'(acc_valid), 0);
    rdy_toggle = 0;
    step();
    check("img_busy_pending", 32'(busy), 1);

    // Label 4'b0111 in two beats, three idle cycles apart
    p0 = res_pulses;
    label_beat(2'b01);
    check("lbl_hi_no_pulse", 32'(res_valid), 0);
    repeat (3) step();
    label_beat(2'b11);
    check("lbl_valid", 32'(res_valid), 1);
    check("lbl_value", 32'(res_label), 7);
    check("lbl_bad", 32'(res_bad), 0);
    check("lbl_cnt_1", 32'(lbl_cnt), 1);
    check("lbl_busy", 32'(busy), 0);
    step();
    check("lbl_pulse_end", 32'(res_valid), 0);
    check("lbl_one_pulse", 32'(res_pulses - p0), 1);

    // Spurious beat with nothing outstanding
    p0 = res_pulses;
    label_beat(2'b10);
    check("spur_err", 32'(err_spurious), 1);
    repeat (2) step();
    check("spur_no_pulse", 32'(res_pulses - p0), 0);
    check("spur_lbl_cnt", 32'(lbl_cnt), 1);

    // Outstanding limit: two images, no labels
    repeat (2) begin
      beat_q.delete();
      beat_mode.delete();
      do_cmd(1'b1);
      send_words(200, 1'b0, 16'h0000);
      wait_beats(200);
    end
    check("lim_img_cnt", 32'(img_cnt), 3);
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    #1;
    check("lim_block_img", 32'(cmd_ready), 0);
    cmd_op = 1'b0;
    #1;
    check("lim_block_wt", 32'(cmd_ready), 0);
    cmd_op = 1'b1;
    label_beat(2'b11);
    check("lim_hi_no_pulse", 32'(res_valid), 0);
    label_beat(2'b00);
    check("lim_lbl_valid", 32'(res_valid), 1);
    check("lim_lbl_value", 32'(res_label), 32'hC);
    check("lim_lbl_bad", 32'(res_bad), 1);
    check("lim_lbl_cnt", 32'(lbl_cnt), 2);
    check("lim_third_ready", 32'(cmd_ready), 1);
    cmd_op = 1'b0;
    #1;
    check("lim_wt_still_blocked", 32'(cmd_ready), 0);
    cmd_op = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("spur_sticky", 32'(err_spurious), 1);

    // Third image abandoned by reset after 100 words
    send_words(100, 1'b0, 16'h0000);
    rst = 1'b1;
    step();
    check("mid_rst_cmd_ready", 32'(cmd_ready), 0);
    check("mid_rst_valid", 32'(acc_valid), 0);
    check("mid_rst_data", 32'(acc_data), 0);
    check("mid_rst_mode", 32'(acc_mode), 0);
    check("mid_rst_res_valid", 32'(res_valid), 0);
    check("mid_rst_res_label", 32'(res_label), 0);
    check("mid_rst_res_bad", 32'(res_bad), 0);
    check("mid_rst_err", 32'(err_spurious), 0);
    rst = 1'b0;
    step();
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_img_cnt", 32'(img_cnt), 0);
    check("mid_rst_lbl_cnt", 32'(lbl_cnt), 0);

    // Fresh image after reset
    beat_q.delete();
    beat_mode.delete();
    do_cmd(1'b1);
    send_words(200, 1'b0, 16'h0000);
    wait_beats(200);
    check_image_order("post_rst_order");
    check("post_rst_img_cnt", 32'(img_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bnn_host_link.md
Name: bnn_host_link

Overview:
- Host-side initiator for the BNN accelerator top's external link: it drives the accelerator's `mode_port`, `data_in_port`, `in_valid_port` and `in_ready_port`.
- It also receives `out_en_port` and `data_out_port`.
- It sequences a weight-load burst (6 conv1 + 60 fc1 words, bit-reversed on the wire) and 200-word image bursts from a host word stream.
- It reassembles each 2-beat label into a 4-bit class result.
- It sits in the FPGA/SoC wrapper between the host DMA FIFO and the accelerator pads.

Parameters:
- DATA_W, 16, link word width.
- WT_WORDS, 66, weight words per load burst (6 conv1 + 60 fc1).
- IMG_WORDS, 200, words per image.
- MAX_OUT, 2, maximum images sent without a returned label.
- CNT_W, 16, width of the status counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  1  0 = load weights, 1 = run one image.
- wd_valid  in  1  host word valid.
- wd_ready  out  1  host word accepted.
- wd_data  in  DATA_W  host word, natural bit order.
- acc_mode  out  1  to the accelerator's mode_port: 1 = weight, 0 = image.
- acc_valid  out  1  to in_valid_port.
- acc_data  out  DATA_W  to data_in_port.
- acc_ready  in  1  from in_ready_port.
- acc_out_en  in  1  from out_en_port; one label beat.
- acc_dout  in  2  from data_out_port.
- res_valid  out  1  one-cycle label pulse.
- res_label  out  4  reassembled label.
- res_bad  out  1  high with res_valid when label > 9.
- err_spurious  out  1  sticky: a label beat arrived with nothing outstanding.
- busy  out  1  state != IDLE or outstanding != 0.
- img_cnt  out  CNT_W  images fully sent (wraps).
- lbl_cnt  out  CNT_W  labels received (wraps).

Behaviour:
- Reset: synchronous on rst; all state, counters and flags cleared.
  - Reset values: cmd_ready=0 during the rst cycle; acc_mode=0, acc_valid=0, acc_data=0, res_valid=0, res_label=0, res_bad=0, err_spurious=0, state=IDLE, outstanding=0.
  - Reset mid-burst abandons the burst with no completion; the accelerator must be reset alongside.
- FSM states: IDLE, WEIGHT, IMAGE.
  - IDLE: cmd_ready = (cmd_op==0 && outstanding==0) || (cmd_op==1 && outstanding<MAX_OUT).
  - Weight reload is therefore forbidden while labels are pending.
  - Accepting op 0 sets acc_mode=1 on the next cycle and enters WEIGHT. Accepting op 1 keeps acc_mode=0, enters IMAGE and increments outstanding.
- Word path: acc_valid/acc_data form an output register. A beat is transferred when acc_valid && acc_ready.
  - wd_ready = state in {WEIGHT, IMAGE} && words_loaded < N && (!acc_valid || acc_ready), where N = WT_WORDS or IMG_WORDS.
  - On wd_valid && wd_ready, acc_data loads on the next edge: wd_data bit-reversed in WEIGHT (acc_data[15-k] = wd_data[k]), unmodified in IMAGE. acc_valid is set at the same edge.
  - Latency: 1 cycle from host beat to link.
  - On a transfer with no new load, acc_valid clears. acc_data holds its value while acc_valid && !acc_ready.
- Burst end: when the Nth word transfers, the state returns to IDLE on the next edge, with acc_valid=0.
  - acc_mode returns to 0 on that same edge, so the mode never changes while acc_valid=1.
  - An image end increments img_cnt. Back-to-back commands are allowed: the next burst's first word loads one cycle after IDLE accepts the command.
- Label receiver: flag hi_pend.
  - On acc_out_en with hi_pend=0: hold label[3:2]=acc_dout and set hi_pend.
  - On acc_out_en with hi_pend=1: label[1:0]=acc_dout. Next edge: res_valid=1, res_label=full nibble, res_bad=(label>9), lbl_cnt+1, outstanding-1, hi_pend=0.
  - Beats need not be consecutive cycles.
- Spurious label beat: acc_out_en with outstanding==0 and hi_pend==0 sets err_spurious (sticky until rst). The beat is discarded and outstanding does not underflow.
- Simultaneous image-command acceptance and label completion leave outstanding unchanged. Label reception is independent of the word-path state.

Decomposition:
- Package bnn_link_pkg:
  - state enum {IDLE, WEIGHT, IMAGE};
  - OP_WEIGHT=0, OP_IMAGE=1;
  - WT_WORDS, IMG_WORDS, LABEL_MAX=9.
- One sub-module, bnn_label_rx: hi_pend, nibble assembly, res_* outputs, spurious detection.
- Main module: FSM, word register, counters, outstanding tracking.

Test Plan:
- Weight load, acc_ready=1: after op 0, 66 host words with wd_data=16'h0001 → 66 link beats of 16'h8000 with acc_mode=1; acc_valid and acc_mode fall on the same edge after beat 66; busy=0.
- Image with backpressure: op 1, words 0..199, acc_ready toggling 1/0 → exactly 200 transfers in order, acc_data stable while stalled, acc_mode=0, img_cnt=1.
- Label reassembly: out_en beats 2'b01 then, 3 cycles later, 2'b11 → res_valid pulse with res_label=7, res_bad=0, lbl_cnt=1, outstanding=0.
- Outstanding limit: two images sent with no labels → cmd_ready=0 for a third op 1 and for op 0. One label of 4'hC returned → res_bad=1, and the third image is accepted on the next cycle.
- Spurious and reset: out_en with nothing outstanding → err_spurious=1, no res_valid. rst asserted mid-image at word 100 → all outputs at reset values; a fresh op 1 then sends 200 words.
